// File: rtl/snoop_mem_ctrl_if.sv
// Request, snoop-bus and response signals between processor nodes and the snooping bus controller.
// The controller uses the slave modport; the node side, or a testbench, uses the master modport.
interface snoop_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_proc;
    logic [2:0]  req_msg;
    logic [1:0]  req_block;
    logic [4:0]  req_tag;
    logic [7:0]  req_wdata;
    logic        listen;
    logic [2:0]  bus_m1;
    logic [1:0]  bus_proc;
    logic [1:0]  bus_block;
    logic [4:0]  bus_tag;
    logic [11:0] bus_in;
    logic        resp_valid;
    logic [1:0]  resp_proc;
    logic [7:0]  resp_data;
    logic        resp_from_cache;
    logic [15:0] stat_mem_reads;
    logic [15:0] stat_c2c;

    modport slave (
        input  req_valid, req_proc, req_msg, req_block, req_tag, req_wdata, bus_in,
        output req_ready, listen, bus_m1, bus_proc, bus_block, bus_tag,
               resp_valid, resp_proc, resp_data, resp_from_cache, stat_mem_reads, stat_c2c
    );

    modport master (
        output req_valid, req_proc, req_msg, req_block, req_tag, req_wdata, bus_in,
        input  req_ready, listen, bus_m1, bus_proc, bus_block, bus_tag,
               resp_valid, resp_proc, resp_data, resp_from_cache, stat_mem_reads, stat_c2c
    );
endinterface

// File: rtl/snoop_mem_ctrl.sv
// Shared memory and bus controller of a snooping coherence bus: broadcast, snoop collection,
// write-back absorption and response. Optional statistics counters: define SNOOP_MEM_STATS_EN.
module snoop_mem_ctrl #(
    parameter int SNOOP_CYCLES = 2,
    parameter int ADDR_W       = 7
) (
    input logic             clock,
    input logic             reset,
    snoop_mem_ctrl_if.slave bus
);
    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int CNT_W     = 3;

    localparam logic [2:0] MSG_RD = 3'b001;
    localparam logic [2:0] MSG_WR = 3'b010;
    localparam logic [2:0] MSG_WB = 3'b100;

    typedef enum logic [2:0] {IDLE, BROADCAST, SNOOP, WB_WRITE, RESPOND} state_t;

    state_t             state_q, state_d;
    logic [1:0]         proc_q, proc_d;
    logic [2:0]         msg_q, msg_d;
    logic [1:0]         block_q, block_d;
    logic [4:0]         tag_q, tag_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic               wb_q, wb_d;
    logic [7:0]         snoopData_q, snoopData_d;

    // Memory contents start as mem[a] = a: an entry never written reads back its own address,
    // so only the written flags need a power-up value and reset leaves memory untouched.
    logic [MEM_DEPTH-1:0] written_q = '0;
    logic [7:0]           memData_q [MEM_DEPTH];
    logic [ADDR_W-1:0]    addr;
    logic [7:0]           memRead;
    logic                 memWe;
    logic [7:0]           memWdata;
    logic                 isMiss;

    assign addr    = ADDR_W'({tag_q, block_q});
    assign memRead = written_q[addr] ? memData_q[addr] : 8'(addr);
    assign isMiss  = (msg_q == MSG_RD) || (msg_q == MSG_WR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            proc_q      <= '0;
            msg_q       <= '0;
            block_q     <= '0;
            tag_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            wb_q        <= 1'b0;
            snoopData_q <= '0;
        end else begin
            state_q     <= state_d;
            proc_q      <= proc_d;
            msg_q       <= msg_d;
            block_q     <= block_d;
            tag_q       <= tag_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            wb_q        <= wb_d;
            snoopData_q <= snoopData_d;
        end
    end

    always_ff @(posedge clock) begin
        if (memWe) begin
            memData_q[addr] <= memWdata;
            written_q[addr] <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        proc_d      = proc_q;
        msg_d       = msg_q;
        block_d     = block_q;
        tag_d       = tag_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        hit_d       = hit_q;
        wb_d        = wb_q;
        snoopData_d = snoopData_q;
        memWe       = 1'b0;
        memWdata    = snoopData_q;

        bus.req_ready       = 1'b0;
        bus.listen          = 1'b0;
        bus.bus_m1          = '0;
        bus.bus_proc        = '0;
        bus.bus_block       = '0;
        bus.bus_tag         = '0;
        bus.resp_valid      = 1'b0;
        bus.resp_proc       = '0;
        bus.resp_data       = '0;
        bus.resp_from_cache = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    proc_d  = bus.req_proc;
                    msg_d   = bus.req_msg;
                    block_d = bus.req_block;
                    tag_d   = bus.req_tag;
                    wdata_d = bus.req_wdata;
                    state_d = (bus.req_msg == MSG_WB) ? WB_WRITE : BROADCAST;
                end
            end
            BROADCAST: begin
                bus.listen    = 1'b1;
                bus.bus_m1    = msg_q;
                bus.bus_proc  = proc_q;
                bus.bus_block = block_q;
                bus.bus_tag   = tag_q;
                hit_d         = 1'b0;
                wb_d          = 1'b0;
                snoopData_d   = '0;
                cnt_d         = CNT_W'(SNOOP_CYCLES - 1);
                state_d       = SNOOP;
            end
            SNOOP: begin
                // First responder wins; the exit decision must see a hit captured this very cycle.
                if (bus.bus_in[10] && !hit_q) begin
                    hit_d       = 1'b1;
                    wb_d        = bus.bus_in[11];
                    snoopData_d = bus.bus_in[7:0];
                end
                if (cnt_q == '0) begin
                    state_d = wb_d ? WB_WRITE : RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WB_WRITE: begin
                memWe    = 1'b1;
                memWdata = (msg_q == MSG_WB) ? wdata_q : snoopData_q;
                state_d  = RESPOND;
            end
            RESPOND: begin
                bus.resp_valid = 1'b1;
                bus.resp_proc  = proc_q;
                if (isMiss) begin
                    bus.resp_data       = hit_q ? snoopData_q : memRead;
                    bus.resp_from_cache = hit_q;
                end else if (msg_q == MSG_WB) begin
                    bus.resp_data = wdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SNOOP_MEM_STATS_EN
    logic [15:0] memReads_q;
    logic [15:0] c2c_q;
    logic        countMem;
    logic        countC2c;

    assign countMem = (state_q == RESPOND) && isMiss && !hit_q;
    assign countC2c = (state_q == RESPOND) && isMiss && hit_q;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memReads_q <= '0;
            c2c_q      <= '0;
        end else begin
            if (countMem && (memReads_q != 16'hFFFF)) begin
                memReads_q <= memReads_q + 16'd1;
            end
            if (countC2c && (c2c_q != 16'hFFFF)) begin
                c2c_q <= c2c_q + 16'd1;
            end
        end
    end

    assign bus.stat_mem_reads = memReads_q;
    assign bus.stat_c2c       = c2c_q;
`else
    assign bus.stat_mem_reads = '0;
    assign bus.stat_c2c       = '0;
`endif
endmodule
